// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA operation codes for the memory pipeline
package isa_pkg;

    localparam logic [7:0] OP_LB  = 8'h30;
    localparam logic [7:0] OP_LH  = 8'h31;
    localparam logic [7:0] OP_LW  = 8'h32;
    localparam logic [7:0] OP_LBU = 8'h34;
    localparam logic [7:0] OP_LHU = 8'h35;
    localparam logic [7:0] OP_SB  = 8'h38;
    localparam logic [7:0] OP_SH  = 8'h39;
    localparam logic [7:0] OP_SW  = 8'h3A;

endpackage

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store unit states, sizes, strobes and op decode
package lsu_pkg;
    import isa_pkg::*;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    localparam logic [3:0] WSTRB_NONE    = 4'b0000;
    localparam logic [3:0] WSTRB_BYTE0   = 4'b0001;
    localparam logic [3:0] WSTRB_LO_HALF = 4'b0011;
    localparam logic [3:0] WSTRB_HI_HALF = 4'b1100;
    localparam logic [3:0] WSTRB_WORD    = 4'b1111;

    typedef struct packed {
        logic      valid;
        logic      store;
        lsu_size_e size;
        logic      is_signed;
    } lsu_op_t;

    // Non-memory codes decode with valid=0 so the unit never accepts them.
    function automatic lsu_op_t decode_op(input logic [7:0] op);
        lsu_op_t d;
        d = '{valid: 1'b1, store: 1'b0, size: SZ_WORD, is_signed: 1'b0};
        case (op)
            OP_LB:   begin d.size = SZ_BYTE; d.is_signed = 1'b1; end
            OP_LH:   begin d.size = SZ_HALF; d.is_signed = 1'b1; end
            OP_LW:   d.size = SZ_WORD;
            OP_LBU:  d.size = SZ_BYTE;
            OP_LHU:  d.size = SZ_HALF;
            OP_SB:   begin d.size = SZ_BYTE; d.store = 1'b1; end
            OP_SH:   begin d.size = SZ_HALF; d.store = 1'b1; end
            OP_SW:   begin d.size = SZ_WORD; d.store = 1'b1; end
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic is_aligned(input lsu_size_e size, input logic [1:0] offset);
        case (size)
            SZ_HALF: return offset[0] == 1'b0;
            SZ_WORD: return offset == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input lsu_size_e size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return WSTRB_BYTE0 << offset;
            SZ_HALF: return offset[1] ? WSTRB_HI_HALF : WSTRB_LO_HALF;
            default: return WSTRB_WORD;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input lsu_size_e size, input logic [31:0] data);
        case (size)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory request/acknowledge bus
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wstrb, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wstrb, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_load_formatter.sv
// rtl/lsu_load_formatter.sv - lane select and sign/zero extension of load data
module lsu_load_formatter
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  lsu_size_e   size,
    input  logic        is_signed,
    output logic [31:0] data
);
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Pick the addressed lane, then extend it to a full word.
    always_comb begin
        lane_byte = rdata[8*offset +: 8];
        lane_half = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: data = {{24{is_signed & lane_byte[7]}}, lane_byte};
            SZ_HALF: data = {{16{is_signed & lane_half[15]}}, lane_half};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with timeout
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    input  logic [7:0]          mem_operation,
    input  logic [31:0]         address,
    input  logic [31:0]         store_data,
    output logic                ready_out,
    output logic                busy,
    output logic                done,
    output logic [31:0]         load_data,
    output logic                misaligned_fault,
    output logic                bus_error,
    load_store_unit_if.master   mem
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e  state_q, state_d;
    lsu_op_t     dec;
    logic        accept;
    logic        aligned;
    logic        timeout;

    logic        store_q;
    lsu_size_e   size_q;
    logic        signed_q;
    logic [1:0]  offset_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        we_q;
    logic [31:0] rdata_q;
    logic        mis_q;
    logic        berr_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] fmt_data;

    assign dec     = decode_op(mem_operation);
    assign aligned = is_aligned(dec.size, address[1:0]);
    assign accept  = valid_in && (state_q == ST_IDLE) && dec.valid;
    // The counter holds the number of REQ cycles already spent without ack.
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Next-state logic; an ack in the timeout cycle wins as a normal completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = aligned ? ST_REQ : ST_RESP;
            ST_REQ:  if (mem.ack || timeout) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, request capture, wait counter and response capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            store_q  <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            offset_q <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= WSTRB_NONE;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                store_q  <= dec.store;
                size_q   <= dec.size;
                signed_q <= dec.is_signed;
                offset_q <= address[1:0];
                addr_q   <= {address[31:2], 2'b00};
                wdata_q  <= store_lanes(dec.size, store_data);
                wstrb_q  <= (dec.store && aligned) ? store_strobe(dec.size, address[1:0]) : WSTRB_NONE;
                we_q     <= dec.store && aligned;
                rdata_q  <= '0;
                mis_q    <= !aligned;
                berr_q   <= 1'b0;
                cnt_q    <= '0;
            end else if (state_q == ST_REQ) begin
                if (mem.ack) begin
                    if (!store_q) rdata_q <= mem.rdata;
                end else if (timeout) begin
                    berr_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    lsu_load_formatter u_formatter (
        .rdata     (rdata_q),
        .offset    (offset_q),
        .size      (size_q),
        .is_signed (signed_q),
        .data      (fmt_data)
    );

    assign ready_out        = (state_q == ST_IDLE);
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_RESP);
    assign misaligned_fault = done && mis_q;
    assign bus_error        = done && berr_q;
    assign load_data        = (done && !store_q && !mis_q && !berr_q) ? fmt_data : 32'h0;

    assign mem.req   = (state_q == ST_REQ);
    assign mem.we    = we_q;
    assign mem.addr  = addr_q;
    assign mem.wstrb = wstrb_q;
    assign mem.wdata = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
    import isa_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [7:0]  mem_operation = 8'h00;
    logic [31:0] address = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        ready_out, busy, done, misaligned_fault, bus_error;
    logic [31:0] load_data;

    int n_checks = 0;
    int n_fail = 0;

    load_store_unit_if mem_bus ();

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_in         (valid_in),
        .mem_operation    (mem_operation),
        .address          (address),
        .store_data       (store_data),
        .ready_out        (ready_out),
        .busy             (busy),
        .done             (done),
        .load_data        (load_data),
        .misaligned_fault (misaligned_fault),
        .bus_error        (bus_error),
        .mem              (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: operation properties as byte count, direction and signedness.
    task automatic op_info(input logic [7:0] op, output int nb, output bit st, output bit sg);
        nb = 4; st = 0; sg = 0;
        if (op == OP_LB)  begin nb = 1; sg = 1; end
        if (op == OP_LH)  begin nb = 2; sg = 1; end
        if (op == OP_LBU) nb = 1;
        if (op == OP_LHU) nb = 2;
        if (op == OP_SB)  begin nb = 1; st = 1; end
        if (op == OP_SH)  begin nb = 2; st = 1; end
        if (op == OP_SW)  st = 1;
    endtask

    // One complete operation; k = cycle of ack (0 = never acknowledge).
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rd, input int k);
        int nb, off, done_cyc;
        bit st, sg, mis, berr;
        longint v;
        logic [31:0] exp_ld, exp_wd;
        logic [3:0] exp_st;
        op_info(op, nb, st, sg);
        off  = int'(addr % 4);
        mis  = (addr % nb) != 0;
        berr = (k == 0) || (k > TMO);
        v = longint'(rd >> (8 * off));
        if (nb < 4) v = v & ((64'd1 << (8 * nb)) - 1);
        if (sg && nb < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
        exp_ld = v[31:0];
        exp_st = st ? 4'(((1 << nb) - 1) << off) : 4'b0000;
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = sd[8*(i % nb) +: 8];

        @(negedge clk);
        chk("ready_before", ready_out, 1);
        valid_in = 1'b1; mem_operation = op; address = addr; store_data = sd;
        @(posedge clk); #1;
        valid_in = 1'b0; mem_operation = 8'($urandom); address = $urandom; store_data = $urandom;

        if (mis) begin
            @(negedge clk);
            chk("mis_done", done, 1);
            chk("mis_fault", misaligned_fault, 1);
            chk("mis_berr", bus_error, 0);
            chk("mis_req", mem_bus.req, 0);
            chk("mis_ld", load_data, 0);
        end else begin
            done_cyc = berr ? TMO + 1 : k + 1;
            for (int c = 1; c < done_cyc; c++) begin
                @(negedge clk);
                chk("req_high", mem_bus.req, 1);
                chk("req_nodone", done, 0);
                chk("req_addr", mem_bus.addr, {addr[31:2], 2'b00});
                chk("req_we", mem_bus.we, st);
                chk("req_wstrb", mem_bus.wstrb, exp_st);
                if (st) chk("req_wdata", mem_bus.wdata, exp_wd);
                mem_bus.ack = (c == k);
                mem_bus.rdata = (c == k) ? rd : $urandom;
            end
            @(negedge clk);
            mem_bus.ack = 1'b0;
            chk("resp_done", done, 1);
            chk("resp_req", mem_bus.req, 0);
            chk("resp_berr", bus_error, berr);
            chk("resp_mis", misaligned_fault, 0);
            if (berr) chk("resp_ld_zero", load_data, 0);
            else if (!st) chk("resp_ld", load_data, exp_ld);
        end
        // Spurious ack while idle must be ignored.
        mem_bus.ack = 1'b1;
        @(negedge clk);
        mem_bus.ack = 1'b0;
        chk("post_done", done, 0);
        chk("post_ready", ready_out, 1);
    endtask

    initial begin
        logic [7:0] ops [8];
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        mem_bus.ack = 1'b0;
        mem_bus.rdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", mem_bus.req, 0);
        chk("rst_we", mem_bus.we, 0);
        chk("rst_wstrb", mem_bus.wstrb, 0);
        chk("rst_addr", mem_bus.addr, 0);
        chk("rst_wdata", mem_bus.wdata, 0);
        chk("rst_ld", load_data, 0);
        chk("rst_flags", {misaligned_fault, bus_error}, 0);
        rst_n = 1'b1;

        // Directed scenarios from the requirements.
        run_op(OP_LB, 32'h0000_1003, 32'h0, 32'h80FF_FF11, 1);
        run_op(OP_SH, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 2);
        run_op(OP_LW, 32'h0000_3001, 32'h0, 32'h0, 1);
        run_op(OP_LHU, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 0);
        run_op(OP_LW, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, TMO);

        // Non-memory code must be ignored.
        @(negedge clk);
        valid_in = 1'b1; mem_operation = 8'hFF; address = 32'h100;
        @(negedge clk);
        valid_in = 1'b0;
        chk("bad_op_ready", ready_out, 1);
        chk("bad_op_req", mem_bus.req, 0);
        chk("bad_op_done", done, 0);

        // Reset while a request is outstanding.
        @(negedge clk);
        valid_in = 1'b1; mem_operation = OP_LW; address = 32'h0000_6000;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_req_high", mem_bus.req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", mem_bus.req, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", ready_out, 1);
        chk("mid_rst_nodone", done, 0);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            int k;
            k = int'($urandom_range(1, 6));
            if (n % 13 == 5) k = 0;
            if (n % 11 == 7) k = TMO;
            run_op(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom, k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
